// File: rtl/phase_sequencer_if.sv
// Control and status bundle for phase_sequencer: sequencing controls in,
// registered phase/cycle status out.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 3,
    parameter int CYCLE_W    = 16
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    // No valid/ready pairs here: every control is a level sampled on each
    // rising Cin, and every status output is a flop that is valid each cycle.
    logic                  Advance;
    logic                  Mode;
    logic                  Step;
    logic                  Halt_Req;
    logic                  Resume;
    logic [NUM_PHASES-1:0] Phase_Out;
    logic [IDX_W-1:0]      Phase_Idx;
    logic                  Cycle_Start;
    logic [CYCLE_W-1:0]    Cycle_Count;
    logic                  Halted;

    modport master (
        output Advance, Mode, Step, Halt_Req, Resume,
        input  Phase_Out, Phase_Idx, Cycle_Start, Cycle_Count, Halted
    );

    modport slave (
        input  Advance, Mode, Step, Halt_Req, Resume,
        output Phase_Out, Phase_Idx, Cycle_Start, Cycle_Count, Halted
    );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot phase sequencer with free-run / single-step advance, a completed-
// cycle counter and a halt-at-wrap / resume control FSM.
module phase_sequencer #(
    parameter int NUM_PHASES = 3,
    parameter int CYCLE_W    = 16
) (
    input  logic                 Cin,
    input  logic                 Reset,
    phase_sequencer_if.slave     bus,
    output logic                 state_dbg
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  step_d_q, step_d_d;
    logic [IDX_W-1:0]      phase_idx_q, phase_idx_d;
    logic [NUM_PHASES-1:0] phase_out_q, phase_out_d;
    logic [CYCLE_W-1:0]    cycle_count_q, cycle_count_d;
    logic                  cycle_start_q, cycle_start_d;

    logic step_edge;
    logic adv;
    logic wrap;

    always_ff @(posedge Cin or posedge Reset) begin
        if (Reset) begin
            state_q       <= RUN;
            step_d_q      <= 1'b0;
            phase_idx_q   <= '0;
            phase_out_q   <= NUM_PHASES'(1);
            cycle_count_q <= '0;
            cycle_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_d_q      <= step_d_d;
            phase_idx_q   <= phase_idx_d;
            phase_out_q   <= phase_out_d;
            cycle_count_q <= cycle_count_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d_d      = bus.Step;
        phase_idx_d   = phase_idx_q;
        phase_out_d   = phase_out_q;
        cycle_count_d = cycle_count_q;
        cycle_start_d = 1'b0;

        // Step edges seen in free-run or while halted are simply dropped.
        step_edge = bus.Step & ~step_d_q;
        adv       = (state_q == RUN) &
                    ((~bus.Mode & bus.Advance) | (bus.Mode & step_edge));
        wrap      = adv & (phase_idx_q == LAST_IDX);

        if (adv) begin
            phase_idx_d = wrap ? '0 : phase_idx_q + IDX_W'(1);
            phase_out_d = {phase_out_q[NUM_PHASES-2:0], phase_out_q[NUM_PHASES-1]};
        end

        if (wrap) begin
            cycle_count_d = cycle_count_q + CYCLE_W'(1);
            cycle_start_d = 1'b1;
        end

        unique case (state_q)
            RUN:     if (wrap && bus.Halt_Req) state_d = HALTED;
            HALTED:  if (bus.Resume)           state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign bus.Phase_Out   = phase_out_q;
    assign bus.Phase_Idx   = phase_idx_q;
    assign bus.Cycle_Start = cycle_start_q;
    assign bus.Cycle_Count = cycle_count_q;
    assign bus.Halted      = (state_q == HALTED);
    assign state_dbg       = state_q;
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameters SHALL be:
- NUM_PHASES, default 3, number of one-hot phases (legal range 2..16).
- CYCLE_W, default 16, width of the completed-cycle counter (legal range 4..32).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Cin, in, 1: sole clock; all state updates on its rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Advance, in, 1: free-run enable, sampled every Cin edge.
- Mode, in, 1: 0 = free-run, 1 = single-step.
- Step, in, 1: single-step request, level input; one advance per rising edge of Step.
- Halt_Req, in, 1: halt at the next phase wrap.
- Resume, in, 1: leave HALTED.
- Phase_Out, out, NUM_PHASES: one-hot phase outputs, registered.
- Phase_Idx, out, $clog2(NUM_PHASES): index of the active phase, registered.
- Cycle_Start, out, 1: one-Cin pulse on entry to phase 0 by wrap.
- Cycle_Count, out, CYCLE_W: completed-cycle counter.
- Halted, out, 1: high while in HALTED.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named Cin and Reset.

Function
REQ-004 The block SHALL have two states, RUN and HALTED; Halted SHALL equal (state==HALTED).
REQ-005 Step edge detection SHALL use a registered copy Step_d, updated every Cin edge in all states and modes; step_edge = Step & ~Step_d.
REQ-006 The advance condition in RUN SHALL be adv = (Mode==0 & Advance) | (Mode==1 & step_edge); in HALTED, adv SHALL be 0.
REQ-007 On adv, Phase_Idx SHALL increment by one, and SHALL wrap from NUM_PHASES-1 to 0.
REQ-008 Phase_Out SHALL be one-hot at all times after reset, with bit Phase_Idx set.
REQ-009 Phase_Out and Phase_Idx SHALL change on the same Cin edge as the advance (latency 1 from the sampled input).
REQ-010 When adv is 0, Phase_Out, Phase_Idx and Cycle_Count SHALL hold, and Cycle_Start SHALL be 0.
REQ-011 On a wrap (adv while Phase_Idx==NUM_PHASES-1):
- Cycle_Count SHALL increment modulo 2^CYCLE_W (all-ones wraps to 0, no saturation or flag).
- Cycle_Start SHALL be 1 for exactly the Cin cycle in which Phase_Idx first reads 0.
REQ-012 If Halt_Req is 1 on the Cin edge of a wrap, the state SHALL go RUN->HALTED on that edge. Phase_Idx=0, the Cycle_Count increment and the Cycle_Start pulse SHALL still occur.
REQ-013 Halt_Req at any other time SHALL have no effect. Halt_Req is not latched: it must be high on the wrap edge to take effect.
REQ-014 In HALTED, Resume=1 SHALL return the state to RUN on the next Cin edge; no advance SHALL occur on that edge.
REQ-015 Resume in RUN SHALL be ignored.
REQ-016 If Resume and Halt_Req are both high in HALTED, Resume SHALL win. The block SHALL halt again only at the next wrap.
REQ-017 A Mode change SHALL take effect on the next Cin edge, with no phase change caused by the switch itself.
REQ-018 A Step rising edge while Mode==0 or while HALTED SHALL be discarded, not queued.
REQ-019 Simultaneous Advance=1 and a step_edge SHALL produce at most one advance per Cin edge.

Reset
REQ-020 While Reset=1, regardless of Cin, outputs SHALL be:
- Phase_Out = {{NUM_PHASES-1{0}},1}
- Phase_Idx = 0
- Cycle_Count = 0
- Cycle_Start = 0
- Halted = 0
- state = RUN
- Step_d = 0
REQ-021 Reset asserted mid-cycle or while HALTED SHALL abandon the current phase immediately, with no Cycle_Start or Cycle_Count update.
REQ-022 The first advance after Reset deasserts SHALL occur on the first Cin edge where adv=1 and Reset=0.

Verification (NUM_PHASES=3, CYCLE_W=4 unless stated)
REQ-023 Free-run: Mode=0, Advance=1 for 7 edges -> Phase_Out 001,010,100,001,010,100,001,010; Cycle_Start high on both returns to 001; Cycle_Count=2.
REQ-024 Single-step: Mode=1, Step held high 5 edges then low 2 then high 1 -> exactly two advances, Phase_Idx 0->1->2; Advance=1 throughout has no effect.
REQ-025 Halt/resume: Halt_Req=1 during free-run -> Halted=1 with Phase_Out=001 on the wrap edge; Phase_Out holds 10 edges; Resume pulse -> Halted=0 next edge, Phase_Out=010 one edge later.
REQ-026 Counter wrap: 16 full cycles from reset -> Cycle_Count 15->0 on the 16th wrap, Cycle_Start pulses normally.
REQ-027 Async reset mid-phase: Reset asserted between Cin edges at Phase_Idx=2, Cycle_Count=5 -> outputs reach reset values before the next Cin edge; no Cycle_Start pulse.
REQ-028 NUM_PHASES=5 build: 10 free-run edges -> Phase_Idx 0..4 twice, Phase_Out one-hot every cycle (assertion), Cycle_Count=2.
